// File: rtl/axil_reg_initiator.sv
// AXI4-Lite slave to GLB register-interface initiator: one transaction at a time,
// with round-robin write/read arbitration and a bounded wait for read data.
module axil_reg_initiator #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RD_TIMEOUT = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic                    reg_wr_en,
  output logic                    reg_wr_clk_en,
  output logic [ADDR_WIDTH-1:0]   reg_wr_addr,
  output logic [DATA_WIDTH-1:0]   reg_wr_data,
  output logic                    reg_rd_en,
  output logic                    reg_rd_clk_en,
  output logic [ADDR_WIDTH-1:0]   reg_rd_addr,
  input  logic [DATA_WIDTH-1:0]   reg_rd_data,
  input  logic                    reg_rd_data_valid,
  output logic [7:0]              rd_timeout_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_BRESP, S_RD, S_RD_WAIT, S_RRESP
  } state_t;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [7:0] C_RD_TIMEOUT = 8'(RD_TIMEOUT);

  state_t                r_state;
  logic                  r_last_grant_rd;
  logic [7:0]            r_wait_cnt;
  logic [7:0]            r_rd_timeout_cnt;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_reg_wr_en;
  logic                  r_reg_wr_clk_en;
  logic [ADDR_WIDTH-1:0] r_reg_wr_addr;
  logic [DATA_WIDTH-1:0] r_reg_wr_data;
  logic                  r_reg_rd_en;
  logic                  r_reg_rd_clk_en;
  logic [ADDR_WIDTH-1:0] r_reg_rd_addr;

  logic w_idle;
  logic w_wr_elig;
  logic w_rd_elig;
  logic w_grant_wr;
  logic w_grant_rd;

  // A contested grant goes to whichever side the flag says did not go last.
  assign w_idle     = (r_state == S_IDLE);
  assign w_wr_elig  = awvalid && wvalid;
  assign w_rd_elig  = arvalid;
  assign w_grant_wr = w_idle && w_wr_elig && (!w_rd_elig || r_last_grant_rd);
  assign w_grant_rd = w_idle && w_rd_elig && (!w_wr_elig || !r_last_grant_rd);

  // NOTE: the AXI readies are combinational so the address/data handshake completes
  // in the grant cycle itself; everything else leaving the block is registered.
  assign awready = w_grant_wr;
  assign wready  = w_grant_wr;
  assign arready = w_grant_rd;

  assign bvalid         = r_bvalid;
  assign bresp          = r_bresp;
  assign rvalid         = r_rvalid;
  assign rresp          = r_rresp;
  assign rdata          = r_rdata;
  assign reg_wr_en      = r_reg_wr_en;
  assign reg_wr_clk_en  = r_reg_wr_clk_en;
  assign reg_wr_addr    = r_reg_wr_addr;
  assign reg_wr_data    = r_reg_wr_data;
  assign reg_rd_en      = r_reg_rd_en;
  assign reg_rd_clk_en  = r_reg_rd_clk_en;
  assign reg_rd_addr    = r_reg_rd_addr;
  assign rd_timeout_cnt = r_rd_timeout_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_last_grant_rd  <= 1'b1;
      r_wait_cnt       <= '0;
      r_rd_timeout_cnt <= '0;
      r_bvalid         <= 1'b0;
      r_bresp          <= RESP_OKAY;
      r_rvalid         <= 1'b0;
      r_rresp          <= RESP_OKAY;
      r_rdata          <= '0;
      r_reg_wr_en      <= 1'b0;
      r_reg_wr_clk_en  <= 1'b0;
      r_reg_wr_addr    <= '0;
      r_reg_wr_data    <= '0;
      r_reg_rd_en      <= 1'b0;
      r_reg_rd_clk_en  <= 1'b0;
      r_reg_rd_addr    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_wr) begin
            r_last_grant_rd <= ~r_last_grant_rd;
            if (&wstrb) begin
              r_reg_wr_addr   <= awaddr;
              r_reg_wr_data   <= wdata;
              r_reg_wr_en     <= 1'b1;
              r_reg_wr_clk_en <= 1'b1;
              r_state         <= S_WR;
            end else begin
              // Partial writes are refused outright; the register side never sees them.
              r_bvalid <= 1'b1;
              r_bresp  <= RESP_SLVERR;
              r_state  <= S_BRESP;
            end
          end else if (w_grant_rd) begin
            r_last_grant_rd <= ~r_last_grant_rd;
            r_reg_rd_addr   <= araddr;
            r_reg_rd_en     <= 1'b1;
            r_reg_rd_clk_en <= 1'b1;
            r_state         <= S_RD;
          end
        end
        S_WR: begin
          r_reg_wr_en <= 1'b0;
          r_bvalid    <= 1'b1;
          r_bresp     <= RESP_OKAY;
          r_state     <= S_BRESP;
        end
        S_BRESP: begin
          r_reg_wr_clk_en <= 1'b0;
          if (r_bvalid && bready) begin
            r_bvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_RD: begin
          r_reg_rd_en <= 1'b0;
          r_wait_cnt  <= '0;
          r_state     <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (reg_rd_data_valid) begin
            r_rdata         <= reg_rd_data;
            r_rresp         <= RESP_OKAY;
            r_rvalid        <= 1'b1;
            r_reg_rd_clk_en <= 1'b0;
            r_state         <= S_RRESP;
          end else if (r_wait_cnt + 8'd1 == C_RD_TIMEOUT) begin
            r_rdata         <= '0;
            r_rresp         <= RESP_SLVERR;
            r_rvalid        <= 1'b1;
            r_reg_rd_clk_en <= 1'b0;
            if (r_rd_timeout_cnt != 8'hFF) r_rd_timeout_cnt <= r_rd_timeout_cnt + 8'd1;
            r_state         <= S_RRESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_RRESP: begin
          if (r_rvalid && rready) begin
            r_rvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axil_reg_initiator.md
# axil_reg_initiator

AXI4-Lite slave to register-interface initiator bridge for the global buffer configuration path. It accepts single-beat AXI4-Lite writes and reads from the host and issues them as wr_en/rd_en strobes on the GLB register interface, with the matching clock enables. Read data is returned when the responder asserts rd_data_valid, or with an error after a bounded wait. The block sits between the top-level AXI4-Lite port and the GLB register responder, and it is the only initiator on that interface.

## Interface
- ADDR_WIDTH, 32, address width on both the AXI and register sides.
- DATA_WIDTH, 32, data width on both sides. wstrb width is DATA_WIDTH/8.
- RD_TIMEOUT, 8, maximum number of RD_WAIT cycles before a read is failed. Legal range is 1 to 255.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- awaddr  in  ADDR_WIDTH.  awvalid  in  1.  awready  out  1.
- wdata  in  DATA_WIDTH.  wstrb  in  DATA_WIDTH/8.  wvalid  in  1.  wready  out  1.
- bresp  out  2.  bvalid  out  1.  bready  in  1.
- araddr  in  ADDR_WIDTH.  arvalid  in  1.  arready  out  1.
- rdata  out  DATA_WIDTH.  rresp  out  2.  rvalid  out  1.  rready  in  1.
- reg_wr_en  out  1  register write strobe, one cycle.
- reg_wr_clk_en  out  1  write-side clock enable.
- reg_wr_addr  out  ADDR_WIDTH.
- reg_wr_data  out  DATA_WIDTH.
- reg_rd_en  out  1  register read strobe, one cycle.
- reg_rd_clk_en  out  1  read-side clock enable.
- reg_rd_addr  out  ADDR_WIDTH.
- reg_rd_data  in  DATA_WIDTH.
- reg_rd_data_valid  in  1  read data valid, sampled in RD_WAIT only.
- rd_timeout_cnt  out  8  saturating count of timed-out reads.

## Operation
- FSM states: IDLE, WR, BRESP, RD, RD_WAIT, RRESP. One transaction is outstanding at a time.
- In IDLE, a write is eligible only when awvalid and wvalid are both high. awready and wready assert together, combinationally, in the grant cycle. The two channels are never accepted separately.
- In IDLE, a read is eligible when arvalid is high. arready asserts in the grant cycle.
- When a write and a read are both eligible, round-robin arbitration selects one. A last_grant flag flips on every grant. Its reset value is "read", so the first contested grant goes to the write.
- Write grant with wstrb all ones:
  - Latch the address and data, then go to WR.
  - In WR, reg_wr_en=1 and reg_wr_clk_en=1. Next state is BRESP.
  - In BRESP, bvalid=1 and bresp=OKAY. reg_wr_clk_en stays high in the first BRESP cycle only.
  - Return to IDLE on bvalid&&bready.
- Write grant with any wstrb bit low: no register write is issued. Go directly to BRESP with bresp=SLVERR (2'b10).
- Read grant:
  - Latch the address, then go to RD.
  - In RD, reg_rd_en=1 and reg_rd_clk_en=1. Next state is RD_WAIT with the wait counter at 0.
  - In RD_WAIT, reg_rd_clk_en=1. If reg_rd_data_valid is high, capture reg_rd_data into rdata, set rresp=OKAY and go to RRESP.
  - Otherwise the counter increments. When it reaches RD_TIMEOUT, set rdata=0 and rresp=SLVERR, increment rd_timeout_cnt (saturating at 255), and go to RRESP.
  - Valid has priority over timeout in the same cycle.
- In RRESP, rvalid=1. Return to IDLE on rvalid&&rready.
- reg_rd_data_valid is ignored in every state except RD_WAIT. A late response after a timeout is dropped.
- reg_wr_addr, reg_wr_data and reg_rd_addr are registered. They hold their last value outside strobe cycles.

## Timing
- Reset values: all ready/valid outputs 0, reg_* strobes and clock enables 0, addr/data/rdata 0, bresp/rresp 0, rd_timeout_cnt 0, state IDLE.
- Reset mid-transaction returns the block to IDLE on the next edge. No B or R response is generated for the aborted transaction. rd_timeout_cnt clears.
- Write, with the grant in cycle N:
  - reg_wr_en is high in cycle N+1.
  - bvalid is high from N+2 onward.
  - reg_wr_clk_en is high in N+1 and N+2.
  - Minimum spacing between writes is 3 cycles when bready is held high.
- Read, with the grant in cycle N:
  - reg_rd_en is high in cycle N+1.
  - If valid arrives in cycle N+1+k (k≥1, k≤RD_TIMEOUT), rvalid is high from N+2+k onward.
  - On timeout, rvalid is high at N+2+RD_TIMEOUT.
- BRESP/RRESP hold bvalid/rvalid and their payload stable until accepted. Ready inputs low stall indefinitely.
- AXI ready outputs are never high outside IDLE.

## Test plan
- Write 0xDEADBEEF to 0x0000_0104 with wstrb=4'hF and bready=1 -> reg_wr_en pulses one cycle with addr 0x104 and data 0xDEADBEEF, then bvalid with bresp=0 two cycles after the grant.
- Write with wstrb=4'h3 -> reg_wr_en never asserts, and bresp=2'b10.
- Read 0x0000_0200 with the responder returning 0x12345678 at k=2 -> rdata=0x12345678, rresp=0, rvalid high at N+4.
- Read with no valid and RD_TIMEOUT=8 -> rvalid at N+10 with rdata=0 and rresp=2'b10, and rd_timeout_cnt becomes 1. A valid arriving at N+12 is ignored.
- awvalid, wvalid and arvalid high together from reset, repeatedly -> grants alternate write, read, write, read. Also awvalid high with wvalid low -> no awready until wvalid rises.
- Assert reset during RD_WAIT and hold bready/rready low through RESP -> outputs return to their reset values and no response is generated. Separately, with bready/rready held low, bvalid/rvalid and their payload stay stable until the ready input rises.
